frame_addr_gen: RTL and testbench
=================================

Name: frame_addr_gen

Overview:
Upstream stage of the camera scaling path. It maps the display raster position (hcount/vcount) to a read address into the 240x320 camera frame buffer, using pixel replication at one of three scale settings. It also delays the raster sideband signals so they line up with the BRAM read data arriving at the downstream scale/gating stage. The scale setting is latched only at frame start, so a frame never tears.

Parameters:
SRC_W, 240, camera frame width in pixels
SRC_H, 320, camera frame height in pixels
ADDR_W, 17, frame buffer address width (SRC_W*SRC_H = 76800 < 2^17)
BRAM_LATENCY, 2, read latency of the frame buffer BRAM in cycles

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous, active-low reset
scale_in  input  2  requested scale: 00 = 1x, 01 = 2x, 10 = 8/3x, 11 = off
hcount_in  input  11  raster x
vcount_in  input  10  raster y
hsync_in  input  1  raster hsync
vsync_in  input  1  raster vsync
blank_in  input  1  raster blanking
addr_out  output  ADDR_W  frame buffer read address
in_region_out  output  1  high when addr_out targets a real source pixel (addr stage)
hcount_out  output  11  hcount_in delayed 2+BRAM_LATENCY cycles
vcount_out  output  10  vcount_in delayed 2+BRAM_LATENCY cycles
hsync_out, vsync_out, blank_out  output  1 each  sideband delayed 2+BRAM_LATENCY cycles
scale_out  output  2  latched scale, aligned with hcount_out/vcount_out

Behaviour:
- Clocking and reset: one clock (clk_in). Reset is asynchronous and active-low on rst_n_in.
- Reset values: every output = 0, every pipeline register = 0, scale_active = 00. Reset asserted mid-stream clears the pipeline immediately. No stale addresses appear after release.
- Scale latch: scale_active <= scale_in only in a cycle where hcount_in == 0 and vcount_in == 0. It holds in all other cycles. All mapping uses scale_active, never scale_in directly.
- Stage 1 (registered): compute sx, sy and in_region from the inputs and scale_active.
  - 00: sx = h, sy = v; region h < 240 and v < 320.
  - 01: sx = h >> 1, sy = v >> 1; region h < 480 and v < 640.
  - 10: sx = (h*3) >> 3, sy = (v*3) >> 3; region h < 640 and v < 853. Intermediates are 13 bits wide; max sx = 239, max sy = 319.
  - 11: in_region = 0.
  - Outside the region: sx = sy = 0.
- Stage 2 (registered): addr_out = sy*SRC_W + sx, computed at ADDR_W width. in_region_out is the stage-1 flag. addr_out latency is 2 cycles from the inputs.
- Sideband: hcount, vcount, hsync, vsync, blank and scale_active pass through a shift pipeline of depth 2+BRAM_LATENCY, so they arrive alongside BRAM data.
- Invariant: addr_out <= SRC_W*SRC_H - 1 at all times.
- Simultaneous frame start and a scale_in change: the new value is latched in that cycle and applies from that pixel onward.
- No backpressure. The block is free-running with one address per clock.

Decomposition:
- Shared package (cam_pkg): SRC_W/SRC_H constants, scale encodings (SCALE_1X, SCALE_2X, SCALE_8_3X, SCALE_OFF), and the per-scale region limits (240/320, 480/640, 640/853). The downstream gating stage reuses the same limits.
- One sub-module: sideband_delay, a parameterised-depth, parameterised-width shift register with async active-low reset, used for the sideband pipeline.

Test Plan:
- Scale 00, sampled at frame start; drive h=10, v=2 -> addr_out=490 and in_region_out=1 two cycles later; hcount_out=10, vcount_out=2 four cycles later (BRAM_LATENCY=2).
- Scale 01; h=101, v=51 -> sx=50, sy=25, addr_out=6050 two cycles later.
- Scale 10; h=639, v=852 -> addr_out=76799. Then h=640 -> addr_out=0, in_region_out=0.
- Scale 00 active; change scale_in to 01 at h=5, v=100 -> addresses keep 1x mapping until the h=0, v=0 cycle. From that cycle, the 2x mapping applies and scale_out flips to 01 four cycles later.
- Scale 11 latched -> addr_out=0 and in_region_out=0 for every raster position; sideband still delayed correctly.
- Pull rst_n_in low mid-line between clock edges -> all outputs 0 immediately. After release, the first non-zero addr_out appears exactly 2 cycles after the first valid in-region input, and scale_active = 00 until the next frame start.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - camera frame geometry, scale encodings and per-scale display region limits
package cam_pkg;

  localparam int CAM_SRC_W = 240;
  localparam int CAM_SRC_H = 320;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'b00,
    SCALE_2X   = 2'b01,
    SCALE_8_3X = 2'b10,
    SCALE_OFF  = 2'b11
  } scale_e;

  // Display-space extent covered by the scaled image; shared with the gating stage
  localparam logic [10:0] LIM_1X_H  = 11'd240;
  localparam logic [9:0]  LIM_1X_V  = 10'd320;
  localparam logic [10:0] LIM_2X_H  = 11'd480;
  localparam logic [9:0]  LIM_2X_V  = 10'd640;
  localparam logic [10:0] LIM_83X_H = 11'd640;
  localparam logic [9:0]  LIM_83X_V = 10'd853;

  typedef struct packed {
    logic [1:0]  scale;
    logic        blank;
    logic        vsync;
    logic        hsync;
    logic [9:0]  vcount;
    logic [10:0] hcount;
  } sideband_t;

  function automatic logic region_hit(input logic [1:0] scale, input logic [10:0] h,
                                      input logic [9:0] v);
    logic hit;
    case (scale)
      SCALE_1X:   hit = (h < LIM_1X_H) && (v < LIM_1X_V);
      SCALE_2X:   hit = (h < LIM_2X_H) && (v < LIM_2X_V);
      SCALE_8_3X: hit = (h < LIM_83X_H) && (v < LIM_83X_V);
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sideband_delay.sv
// rtl/sideband_delay.sv - fixed-depth shift register with asynchronous active-low clear
module sideband_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_addr_gen.sv
// rtl/frame_addr_gen.sv - maps raster position to camera frame buffer address, delays sideband to BRAM data
module frame_addr_gen
  import cam_pkg::*;
#(
  parameter int SRC_W        = CAM_SRC_W,
  parameter int SRC_H        = CAM_SRC_H,
  parameter int ADDR_W       = 17,
  parameter int BRAM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [1:0]        scale_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              in_region_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic [1:0]        scale_out
);

  localparam int SX_W = $clog2(SRC_W);
  localparam int SY_W = $clog2(SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SRC_W);

  logic            frame_start;
  logic [1:0]      scale_active;
  logic [1:0]      scale_eff;
  logic [12:0]     h3;
  logic [12:0]     v3;
  logic            hit;
  logic [SX_W-1:0] sx_nxt, sx_q;
  logic [SY_W-1:0] sy_nxt, sy_q;
  logic            region_q;
  sideband_t       sb_in, sb_out;

  // A scale change presented on the frame-start pixel takes effect on that very pixel
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign scale_eff   = frame_start ? scale_in : scale_active;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scale_active <= SCALE_1X;
    end else if (frame_start) begin
      scale_active <= scale_in;
    end
  end

  assign h3 = 13'(hcount_in) + 13'({hcount_in, 1'b0});
  assign v3 = 13'(vcount_in) + 13'({vcount_in, 1'b0});

  always_comb begin
    sx_nxt = '0;
    sy_nxt = '0;
    hit    = region_hit(scale_eff, hcount_in, vcount_in);
    if (hit) begin
      case (scale_eff)
        SCALE_1X: begin
          sx_nxt = SX_W'(hcount_in);
          sy_nxt = SY_W'(vcount_in);
        end
        SCALE_2X: begin
          sx_nxt = SX_W'(hcount_in >> 1);
          sy_nxt = SY_W'(vcount_in >> 1);
        end
        SCALE_8_3X: begin
          sx_nxt = SX_W'(h3 >> 3);
          sy_nxt = SY_W'(v3 >> 3);
        end
        default: begin
          sx_nxt = '0;
          sy_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sx_q     <= '0;
      sy_q     <= '0;
      region_q <= 1'b0;
    end else begin
      sx_q     <= sx_nxt;
      sy_q     <= sy_nxt;
      region_q <= hit;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out      <= '0;
      in_region_out <= 1'b0;
    end else begin
      addr_out      <= ADDR_W'(sy_q) * ROW_STRIDE + ADDR_W'(sx_q);
      in_region_out <= region_q;
    end
  end

  always_comb begin
    sb_in        = '0;
    sb_in.scale  = scale_eff;
    sb_in.blank  = blank_in;
    sb_in.vsync  = vsync_in;
    sb_in.hsync  = hsync_in;
    sb_in.vcount = vcount_in;
    sb_in.hcount = hcount_in;
  end

  // Two address stages plus the BRAM read latency
  sideband_delay #(
    .DEPTH(2 + BRAM_LATENCY),
    .WIDTH($bits(sideband_t))
  ) u_sideband_delay (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .data_in (sb_in),
    .data_out(sb_out)
  );

  assign hcount_out = sb_out.hcount;
  assign vcount_out = sb_out.vcount;
  assign hsync_out  = sb_out.hsync;
  assign vsync_out  = sb_out.vsync;
  assign blank_out  = sb_out.blank;
  assign scale_out  = sb_out.scale;

endmodule

// File: tb/tb_frame_addr_gen.sv
// tb/tb_frame_addr_gen.sv - self-checking bench for frame_addr_gen
module tb_frame_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scale;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        hs, vs, bl;
  logic [16:0] addr;
  logic        inreg;
  logic [10:0] hco;
  logic [9:0]  vco;
  logic        hso, vso, blo;
  logic [1:0]  sco;

  always #5 clk = ~clk;

  frame_addr_gen dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .scale_in     (scale),
    .hcount_in    (hc),
    .vcount_in    (vc),
    .hsync_in     (hs),
    .vsync_in     (vs),
    .blank_in     (bl),
    .addr_out     (addr),
    .in_region_out(inreg),
    .hcount_out   (hco),
    .vcount_out   (vco),
    .hsync_out    (hso),
    .vsync_out    (vso),
    .blank_out    (blo),
    .scale_out    (sco)
  );

  typedef struct {
    int addr;
    int inr;
    int h;
    int v;
    int hs;
    int vs;
    int bl;
    int sc;
  } exp_t;

  typedef struct {
    int sc;
    int h;
    int v;
    int exp_addr;
    int exp_reg;
  } vec_t;

  exp_t hist[4];
  vec_t tbl[11];
  int   scale_act;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference mapping: display pixel -> source pixel via the scale ratio, row-major address
  function automatic exp_t model(input int sc, input int h, input int v, input int hs_,
                                 input int vs_, input int bl_);
    exp_t e;
    int sx, sy, lim_h, lim_v;
    bit on;
    on = 1'b1;
    case (sc)
      0: begin lim_h = 240; lim_v = 320; sx = h;         sy = v;         end
      1: begin lim_h = 480; lim_v = 640; sx = h / 2;     sy = v / 2;     end
      2: begin lim_h = 640; lim_v = 853; sx = h * 3 / 8; sy = v * 3 / 8; end
      default: begin lim_h = 0; lim_v = 0; sx = 0; sy = 0; on = 1'b0; end
    endcase
    e.inr  = (on && h < lim_h && v < lim_v) ? 1 : 0;
    e.addr = e.inr ? sy * 240 + sx : 0;
    e.h = h; e.v = v; e.hs = hs_; e.vs = vs_; e.bl = bl_; e.sc = sc;
    return e;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 4; i++) hist[i] = '{default: 0};
    scale_act = 0;
  endtask

  // Called at a falling edge: drive one pixel, advance one clock, check all outputs
  task automatic cycle(input int h, input int v, input int sc, input int hs_, input int vs_,
                       input int bl_);
    hc = 11'(h); vc = 10'(v); scale = 2'(sc);
    hs = 1'(hs_); vs = 1'(vs_); bl = 1'(bl_);
    if (h == 0 && v == 0) scale_act = sc;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = model(scale_act, h, v, hs_, vs_, bl_);
    @(negedge clk);
    chk("addr", int'(addr), hist[1].addr);
    chk("in_region", int'(inreg), hist[1].inr);
    chk("addr_bound", (addr <= 17'd76799) ? 1 : 0, 1);
    chk("hcount_out", int'(hco), hist[3].h);
    chk("vcount_out", int'(vco), hist[3].v);
    chk("hsync_out", int'(hso), hist[3].hs);
    chk("vsync_out", int'(vso), hist[3].vs);
    chk("blank_out", int'(blo), hist[3].bl);
    chk("scale_out", int'(sco), hist[3].sc);
  endtask

  task automatic idle(input int sc);
    cycle(700, 700, sc, 0, 0, 1);
  endtask

  initial begin
    int hb[6];
    int h, v, sc;
    hb = '{239, 240, 479, 480, 639, 640};
    tbl[0]  = '{0, 10, 2, 490, 1};
    tbl[1]  = '{1, 101, 51, 6050, 1};
    tbl[2]  = '{2, 639, 852, 76799, 1};
    tbl[3]  = '{2, 640, 852, 0, 0};
    tbl[4]  = '{0, 239, 319, 76799, 1};
    tbl[5]  = '{0, 240, 0, 0, 0};
    tbl[6]  = '{1, 479, 639, 76799, 1};
    tbl[7]  = '{1, 480, 5, 0, 0};
    tbl[8]  = '{3, 10, 2, 0, 0};
    tbl[9]  = '{2, 8, 8, 723, 1};
    tbl[10] = '{2, 639, 853, 0, 0};

    rst_n = 1'b0; scale = 2'b10; hc = '0; vc = '0; hs = 1'b1; vs = 1'b1; bl = 1'b1;
    reset_model();
    repeat (2) @(negedge clk);
    chk("reset_addr", int'(addr), 0);
    chk("reset_in_region", int'(inreg), 0);
    chk("reset_hcount", int'(hco), 0);
    chk("reset_sideband", int'({hso, vso, blo, sco}), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(0, 0, tbl[i].sc, 0, 1, 1);
      cycle(tbl[i].h, tbl[i].v, tbl[i].sc, 1, 0, 0);
      idle(tbl[i].sc);
      chk("tbl_addr", int'(addr), tbl[i].exp_addr);
      chk("tbl_in_region", int'(inreg), tbl[i].exp_reg);
      idle(tbl[i].sc);
      idle(tbl[i].sc);
      chk("tbl_hcount", int'(hco), tbl[i].h);
      chk("tbl_vcount", int'(vco), tbl[i].v);
      chk("tbl_scale_out", int'(sco), tbl[i].sc);
    end

    // Scale request mid-frame waits for the next frame start
    cycle(0, 0, 0, 0, 0, 0);
    cycle(5, 100, 1, 0, 0, 0);
    cycle(6, 100, 1, 0, 0, 0);
    chk("hold_addr_5_100", int'(addr), 24005);
    cycle(0, 0, 1, 0, 0, 0);
    chk("hold_addr_6_100", int'(addr), 24006);
    cycle(101, 51, 1, 0, 0, 0);
    chk("switch_addr_0_0", int'(addr), 0);
    idle(1);
    chk("switch_addr_101_51", int'(addr), 6050);
    chk("switch_scale_out_old", int'(sco), 0);
    idle(1);
    chk("switch_scale_out_new", int'(sco), 1);

    // Off mode: nothing is ever in region
    cycle(0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle($urandom_range(0, 300), $urandom_range(0, 400), 0, 1, 1, 0);
      chk("off_in_region", int'(inreg), 0);
      chk("off_addr", int'(addr), 0);
    end

    // Asynchronous reset mid-line
    cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(101 + i, 51, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_in_region", int'(inreg), 0);
    chk("midrst_hcount", int'(hco), 0);
    chk("midrst_vcount", int'(vco), 0);
    chk("midrst_sideband", int'({hso, vso, blo, sco}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    cycle(10, 2, 1, 0, 0, 0);
    chk("post_rst_addr_first", int'(addr), 0);
    idle(1);
    chk("post_rst_addr_1x", int'(addr), 490);

    // Randomized raster-like stream with occasional frame starts
    for (int n = 0; n < 1500; n++) begin
      sc = int'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin h = 0; v = 0; end
        1, 2: begin h = hb[$urandom_range(0, 5)]; v = int'($urandom_range(0, 900)); end
        3: begin h = int'($urandom_range(0, 700)); v = 852 + int'($urandom_range(0, 1)); end
        default: begin h = int'($urandom_range(0, 900)); v = int'($urandom_range(0, 900)); end
      endcase
      cycle(h, v, sc, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
